// File: rtl/sparc_exu_rml_wintrk.sv
// Per-thread register-window tracker: CWP/CANSAVE/CANRESTORE, spill/fill traps, IRF swap handshake.
// Optional clean-window tracking is built when RML_CLEANWIN_EN is defined.
module sparc_exu_rml_wintrk (
    input  logic        rclk,
    input  logic        reset,
    input  logic        ifu_exu_save_d,
    input  logic        ifu_exu_restore_d,
    input  logic        ifu_exu_wrcwp_d,
    input  logic [2:0]  ifu_exu_wrdata_d,
    input  logic [1:0]  ifu_exu_tid_d,
`ifdef RML_CLEANWIN_EN
    input  logic        ifu_exu_wrcln_d,
    input  logic [2:0]  ifu_exu_wrcln_data_d,
    output logic        rml_cln_trap_w,
`endif
    output logic        rml_rdy,
    output logic [11:0] rml_cwp_all,
    output logic        rml_spill_trap_w,
    output logic        rml_fill_trap_w,
    output logic [1:0]  rml_trap_tid_w,
    output logic        rml_swap_vld,
    output logic [1:0]  rml_swap_tid,
    output logic [2:0]  rml_swap_old_cwp,
    output logic [2:0]  rml_swap_new_cwp
);

    localparam int unsigned NTHR = 4;
    localparam int unsigned NWIN = 8;
    localparam int unsigned CWPW = $clog2(NWIN);
    localparam int unsigned TIDW = $clog2(NTHR);
    localparam logic [CWPW-1:0] CANSAVE_RST = CWPW'(NWIN - 2);

    typedef enum logic [1:0] {IDLE, SWAP1, SWAP2} state_t;

    state_t state, state_nxt;

    logic [CWPW-1:0] cwp        [NTHR];
    logic [CWPW-1:0] cansave    [NTHR];
    logic [CWPW-1:0] canrestore [NTHR];
    logic [CWPW-1:0] cwp_nxt        [NTHR];
    logic [CWPW-1:0] cansave_nxt    [NTHR];
    logic [CWPW-1:0] canrestore_nxt [NTHR];

    logic            spill_nxt;
    logic            fill_nxt;
    logic [TIDW-1:0] trap_tid_nxt;
    logic [TIDW-1:0] swap_tid_nxt;
    logic [CWPW-1:0] swap_old_nxt;
    logic [CWPW-1:0] swap_new_nxt;

    logic wrcln_c;
    logic cln_hit_c;

`ifdef RML_CLEANWIN_EN
    logic [CWPW-1:0] cleanwin     [NTHR];
    logic [CWPW-1:0] cleanwin_nxt [NTHR];
    logic            cln_nxt;

    assign wrcln_c   = ifu_exu_wrcln_d;
    assign cln_hit_c = (cleanwin[ifu_exu_tid_d] == canrestore[ifu_exu_tid_d]);
`else
    assign wrcln_c   = 1'b0;
    assign cln_hit_c = 1'b0;
`endif

    // Request decode, architectural update and FSM next state
    always_comb begin
        state_nxt      = state;
        cwp_nxt        = cwp;
        cansave_nxt    = cansave;
        canrestore_nxt = canrestore;
        spill_nxt      = 1'b0;
        fill_nxt       = 1'b0;
        trap_tid_nxt   = rml_trap_tid_w;
        swap_tid_nxt   = rml_swap_tid;
        swap_old_nxt   = rml_swap_old_cwp;
        swap_new_nxt   = rml_swap_new_cwp;
`ifdef RML_CLEANWIN_EN
        cleanwin_nxt   = cleanwin;
        cln_nxt        = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (ifu_exu_wrcwp_d) begin
                    cwp_nxt[ifu_exu_tid_d] = ifu_exu_wrdata_d;
                    swap_tid_nxt           = ifu_exu_tid_d;
                    swap_old_nxt           = cwp[ifu_exu_tid_d];
                    swap_new_nxt           = ifu_exu_wrdata_d;
                    state_nxt              = SWAP1;
                end else if (!wrcln_c && ifu_exu_save_d) begin
                    if (cansave[ifu_exu_tid_d] == '0) begin
                        spill_nxt    = 1'b1;
                        trap_tid_nxt = ifu_exu_tid_d;
                    end else if (cln_hit_c) begin
`ifdef RML_CLEANWIN_EN
                        cln_nxt      = 1'b1;
`endif
                        trap_tid_nxt = ifu_exu_tid_d;
                    end else begin
                        cwp_nxt[ifu_exu_tid_d]        = cwp[ifu_exu_tid_d] + CWPW'(1);
                        cansave_nxt[ifu_exu_tid_d]    = cansave[ifu_exu_tid_d] - CWPW'(1);
                        canrestore_nxt[ifu_exu_tid_d] = canrestore[ifu_exu_tid_d] + CWPW'(1);
                        swap_tid_nxt                  = ifu_exu_tid_d;
                        swap_old_nxt                  = cwp[ifu_exu_tid_d];
                        swap_new_nxt                  = cwp[ifu_exu_tid_d] + CWPW'(1);
                        state_nxt                     = SWAP1;
                    end
                end else if (!wrcln_c && ifu_exu_restore_d) begin
                    if (canrestore[ifu_exu_tid_d] == '0) begin
                        fill_nxt     = 1'b1;
                        trap_tid_nxt = ifu_exu_tid_d;
                    end else begin
                        cwp_nxt[ifu_exu_tid_d]        = cwp[ifu_exu_tid_d] - CWPW'(1);
                        cansave_nxt[ifu_exu_tid_d]    = cansave[ifu_exu_tid_d] + CWPW'(1);
                        canrestore_nxt[ifu_exu_tid_d] = canrestore[ifu_exu_tid_d] - CWPW'(1);
                        swap_tid_nxt                  = ifu_exu_tid_d;
                        swap_old_nxt                  = cwp[ifu_exu_tid_d];
                        swap_new_nxt                  = cwp[ifu_exu_tid_d] - CWPW'(1);
                        state_nxt                     = SWAP1;
                    end
                end
`ifdef RML_CLEANWIN_EN
                // Clean-window write shares wrcwp priority and never swaps
                if (ifu_exu_wrcln_d) begin
                    cleanwin_nxt[ifu_exu_tid_d] = ifu_exu_wrcln_data_d;
                end
`endif
            end
            SWAP1:   state_nxt = SWAP2;
            SWAP2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, architectural registers and registered outputs
    always_ff @(posedge rclk) begin
        if (reset) begin
            state            <= IDLE;
            cwp              <= '{default: '0};
            cansave          <= '{default: CANSAVE_RST};
            canrestore       <= '{default: '0};
            rml_rdy          <= 1'b1;
            rml_spill_trap_w <= 1'b0;
            rml_fill_trap_w  <= 1'b0;
            rml_trap_tid_w   <= '0;
            rml_swap_vld     <= 1'b0;
            rml_swap_tid     <= '0;
            rml_swap_old_cwp <= '0;
            rml_swap_new_cwp <= '0;
`ifdef RML_CLEANWIN_EN
            cleanwin         <= '{default: CWPW'(NWIN - 1)};
            rml_cln_trap_w   <= 1'b0;
`endif
        end else begin
            state            <= state_nxt;
            cwp              <= cwp_nxt;
            cansave          <= cansave_nxt;
            canrestore       <= canrestore_nxt;
            rml_rdy          <= (state_nxt == IDLE);
            rml_spill_trap_w <= spill_nxt;
            rml_fill_trap_w  <= fill_nxt;
            rml_trap_tid_w   <= trap_tid_nxt;
            rml_swap_vld     <= (state_nxt == SWAP1);
            rml_swap_tid     <= swap_tid_nxt;
            rml_swap_old_cwp <= swap_old_nxt;
            rml_swap_new_cwp <= swap_new_nxt;
`ifdef RML_CLEANWIN_EN
            cleanwin         <= cleanwin_nxt;
            rml_cln_trap_w   <= cln_nxt;
`endif
        end
    end

    // Flatten per-thread CWP registers onto the shared bus
    always_comb begin
        rml_cwp_all = '0;
        for (int t = 0; t < int'(NTHR); t++) begin
            rml_cwp_all[CWPW*t +: CWPW] = cwp[t];
        end
    end

endmodule

// File: tb/tb_sparc_exu_rml_wintrk.sv
// Bench for sparc_exu_rml_wintrk: window model plus directed vectors.
// Define RML_CLEANWIN_EN to exercise the clean-window option.
module tb_sparc_exu_rml_wintrk;

    logic        rclk = 1'b0;
    logic        reset = 1'b1;
    logic        save = 1'b0, restore = 1'b0, wrcwp = 1'b0;
    logic [2:0]  wrdata = '0;
    logic [1:0]  tid = '0;
    logic        rml_rdy, rml_spill_trap_w, rml_fill_trap_w, rml_swap_vld;
    logic [11:0] rml_cwp_all;
    logic [1:0]  rml_trap_tid_w, rml_swap_tid;
    logic [2:0]  rml_swap_old_cwp, rml_swap_new_cwp;
    logic        wrcln_m;
`ifdef RML_CLEANWIN_EN
    logic        wrcln = 1'b0;
    logic [2:0]  wrcln_data = '0;
    logic        rml_cln_trap_w;
    assign wrcln_m = wrcln;
`else
    assign wrcln_m = 1'b0;
`endif

    sparc_exu_rml_wintrk dut (
        .rclk              (rclk),
        .reset             (reset),
        .ifu_exu_save_d    (save),
        .ifu_exu_restore_d (restore),
        .ifu_exu_wrcwp_d   (wrcwp),
        .ifu_exu_wrdata_d  (wrdata),
        .ifu_exu_tid_d     (tid),
`ifdef RML_CLEANWIN_EN
        .ifu_exu_wrcln_d      (wrcln),
        .ifu_exu_wrcln_data_d (wrcln_data),
        .rml_cln_trap_w       (rml_cln_trap_w),
`endif
        .rml_rdy           (rml_rdy),
        .rml_cwp_all       (rml_cwp_all),
        .rml_spill_trap_w  (rml_spill_trap_w),
        .rml_fill_trap_w   (rml_fill_trap_w),
        .rml_trap_tid_w    (rml_trap_tid_w),
        .rml_swap_vld      (rml_swap_vld),
        .rml_swap_tid      (rml_swap_tid),
        .rml_swap_old_cwp  (rml_swap_old_cwp),
        .rml_swap_new_cwp  (rml_swap_new_cwp)
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: integer window counts and a busy-cycle counter
    int m_cwp[4], m_cs[4], m_cr[4], m_cw[4];
    int busy, mt;
    bit m_rdy, m_spill, m_fill, m_cln, m_swv;
    int m_ttid, m_stid, m_old, m_new;
    bit started = 0;

    function automatic logic [11:0] m_cwp_all();
        logic [11:0] v = '0;
        for (int t = 0; t < 4; t++) v = v | 12'((m_cwp[t] % 8) << (3 * t));
        return v;
    endfunction

    always @(posedge rclk) begin
        started = 1;
        if (reset) begin
            for (int t = 0; t < 4; t++) begin
                m_cwp[t] = 0; m_cs[t] = 6; m_cr[t] = 0; m_cw[t] = 7;
            end
            busy = 0; m_rdy = 1; m_spill = 0; m_fill = 0; m_cln = 0; m_swv = 0;
            m_ttid = 0; m_stid = 0; m_old = 0; m_new = 0;
        end else begin
            m_spill = 0; m_fill = 0; m_cln = 0; m_swv = 0;
            if (busy == 0) begin
                mt = int'(tid);
                if (wrcwp) begin
                    m_old = m_cwp[mt]; m_new = int'(wrdata); m_cwp[mt] = int'(wrdata);
                    m_stid = mt; busy = 2; m_swv = 1;
                end else if (!wrcln_m && save) begin
                    if (m_cs[mt] == 0) begin
                        m_spill = 1; m_ttid = mt;
`ifdef RML_CLEANWIN_EN
                    end else if (m_cw[mt] == m_cr[mt]) begin
                        m_cln = 1; m_ttid = mt;
`endif
                    end else begin
                        m_old = m_cwp[mt]; m_cwp[mt] = (m_cwp[mt] + 1) % 8; m_new = m_cwp[mt];
                        m_cs[mt]--; m_cr[mt]++;
                        m_stid = mt; busy = 2; m_swv = 1;
                    end
                end else if (!wrcln_m && restore) begin
                    if (m_cr[mt] == 0) begin
                        m_fill = 1; m_ttid = mt;
                    end else begin
                        m_old = m_cwp[mt]; m_cwp[mt] = (m_cwp[mt] + 7) % 8; m_new = m_cwp[mt];
                        m_cs[mt]++; m_cr[mt]--;
                        m_stid = mt; busy = 2; m_swv = 1;
                    end
                end
`ifdef RML_CLEANWIN_EN
                if (wrcln) m_cw[mt] = int'(wrcln_data);
`endif
            end else begin
                busy--;
            end
            m_rdy = (busy == 0);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge rclk) begin
        if (started) begin
            chk("rdy", rml_rdy, m_rdy);
            chk("cwp_all", rml_cwp_all, m_cwp_all());
            chk("spill", rml_spill_trap_w, m_spill);
            chk("fill", rml_fill_trap_w, m_fill);
            chk("trap_tid", rml_trap_tid_w, m_ttid);
            chk("swap_vld", rml_swap_vld, m_swv);
            chk("swap_tid", rml_swap_tid, m_stid);
            chk("swap_old", rml_swap_old_cwp, m_old);
            chk("swap_new", rml_swap_new_cwp, m_new);
`ifdef RML_CLEANWIN_EN
            chk("cln_trap", rml_cln_trap_w, m_cln);
`endif
        end
    end

    // Present one request for one cycle once rdy is high; returns at the N+1 negedge
    task automatic req(input logic s, input logic r, input logic w,
                       input logic [2:0] wd, input logic [1:0] t);
        int n = 0;
        while (rml_rdy !== 1'b1 && n < 20) begin
            @(negedge rclk);
            n++;
        end
        if (n >= 20) chk("rdy_timeout", 32'(rml_rdy), 32'd1);
        save = s; restore = r; wrcwp = w; wrdata = wd; tid = t;
        @(negedge rclk);
        save = 0; restore = 0; wrcwp = 0; wrdata = '0; tid = '0;
    endtask

    initial begin
        repeat (2) @(negedge rclk);
        reset = 0;
        @(negedge rclk);
        chk("rst_rdy", rml_rdy, 1);
        chk("rst_cwp_all", rml_cwp_all, 12'h000);
        chk("rst_swap_vld", rml_swap_vld, 0);
        chk("rst_spill", rml_spill_trap_w, 0);

        for (int k = 0; k < 6; k++) begin
            req(1, 0, 0, 3'd0, 2'd1);
            chk("save_swap_vld", rml_swap_vld, 1);
            chk("save_old", rml_swap_old_cwp, k);
            chk("save_new", rml_swap_new_cwp, k + 1);
            chk("save_rdy_low", rml_rdy, 0);
        end
        chk("six_saves_cwp", rml_cwp_all, 12'h030);

        req(1, 0, 0, 3'd0, 2'd1);
        chk("spill_pulse", rml_spill_trap_w, 1);
        chk("spill_tid", rml_trap_tid_w, 2'd1);
        chk("spill_rdy", rml_rdy, 1);
        chk("spill_cwp", rml_cwp_all, 12'h030);

        req(0, 1, 0, 3'd0, 2'd2);
        chk("fill_pulse", rml_fill_trap_w, 1);
        chk("fill_tid", rml_trap_tid_w, 2'd2);
        chk("fill_cwp", rml_cwp_all, 12'h030);

        req(0, 0, 1, 3'd7, 2'd0);
        chk("wrpr_old", rml_swap_old_cwp, 0);
        chk("wrpr_new", rml_swap_new_cwp, 7);
        chk("wrpr_cwp", rml_cwp_all, 12'h037);
        req(1, 0, 0, 3'd0, 2'd0);
        chk("wrap_old", rml_swap_old_cwp, 7);
        chk("wrap_new", rml_swap_new_cwp, 0);
        chk("wrap_cwp", rml_cwp_all, 12'h030);
        chk("model_cansave0", m_cs[0], 5);

        req(1, 1, 0, 3'd0, 2'd3);
        chk("prio_cwp", rml_cwp_all, 12'h230);
        chk("prio_new", rml_swap_new_cwp, 1);
        restore = 1; tid = 2'd3;
        @(negedge rclk);
        restore = 0; tid = '0;
        chk("swap2_ignored_cwp", rml_cwp_all, 12'h230);
        chk("swap2_rdy", rml_rdy, 0);
        chk("swap2_vld", rml_swap_vld, 0);
        chk("swap2_hold_new", rml_swap_new_cwp, 1);

        req(0, 0, 1, 3'd0, 2'd2);
        chk("wrpr_same_vld", rml_swap_vld, 1);
        chk("wrpr_same_new", rml_swap_new_cwp, 0);
        req(1, 0, 1, 3'd3, 2'd2);
        chk("wrpr_beats_save", rml_cwp_all, 12'h2f0);
        chk("wrpr_beats_save_new", rml_swap_new_cwp, 3);

        req(1, 0, 0, 3'd0, 2'd3);
        chk("pre_rst_vld", rml_swap_vld, 1);
        reset = 1;
        @(negedge rclk);
        reset = 0;
        chk("midswap_rst_vld", rml_swap_vld, 0);
        chk("midswap_rst_cwp", rml_cwp_all, 12'h000);
        chk("midswap_rst_rdy", rml_rdy, 1);

`ifdef RML_CLEANWIN_EN
        wrcln = 1; wrcln_data = 3'd0; tid = 2'd0;
        @(negedge rclk);
        wrcln = 0; wrcln_data = '0;
        chk("wrcln_rdy", rml_rdy, 1);
        chk("wrcln_no_swap", rml_swap_vld, 0);
        req(1, 0, 0, 3'd0, 2'd0);
        chk("cln_pulse", rml_cln_trap_w, 1);
        chk("cln_tid", rml_trap_tid_w, 2'd0);
        chk("cln_cwp", rml_cwp_all, 12'h000);
        chk("cln_no_swap", rml_swap_vld, 0);
`endif

        repeat (4) @(negedge rclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
